// File: rtl/big_core_pkg.sv
// big_core_pkg: shared payload type and pipe-stage limits for big_core.
package big_core_pkg;

  localparam int unsigned PIPE_PAYLOAD_W  = 64;
  localparam int unsigned PIPE_MAX_STAGES = 8;

  typedef struct packed {
    logic [31:0] PcPlus4;
    logic [31:0] AluOut;
  } t_pipe_payload;

  // Width of an occupancy counter able to hold 0..2*stages.
  function automatic int unsigned pipe_occ_w(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/big_core_pipe_slot.sv
// big_core_pipe_slot: one register stage of the pipe chain. With SKID_EN the
// stage holds a main entry (drives the output) and a skid entry, and its
// upstream ready is the registered !skid_valid. Without it, a single entry
// whose ready passes the downstream ready through combinationally.
module big_core_pipe_slot
  import big_core_pkg::*;
#(
  parameter int unsigned DATA_W  = PIPE_PAYLOAD_W,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        valid_cnt_d
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              push, pop;

  assign in_ready  = SKID_EN ? !skid_valid_q : (!main_valid_q || out_ready);
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = main_valid_q && out_ready;

  // Next-state of main/skid entries; a flush only drops valid bits.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      // Skid full means in_ready was low, so no push can coincide here.
      main_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (push) begin
      if (!main_valid_q || pop) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end else if (SKID_EN) begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end

  assign valid_cnt_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};

  // Entry registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (SKID_EN ? !(main_valid_q && skid_valid_q) : (!main_valid_q || pop)));

endmodule

// File: rtl/big_core_pipe_stage.sv
// big_core_pipe_stage: NUM_STAGES cascaded pipe slots with valid/ready
// handshake, synchronous flush and a registered occupancy count.
module big_core_pipe_stage
  import big_core_pkg::*;
#(
  parameter int unsigned DATA_W     = PIPE_PAYLOAD_W,
  parameter int unsigned NUM_STAGES = 1,
  parameter bit          SKID_EN    = 1'b1
) (
  input  logic                                 Clock,
  input  logic                                 Rst,
  input  logic                                 FlushQ,
  input  logic                                 InValid,
  output logic                                 InReady,
  input  logic [DATA_W-1:0]                    InData,
  output logic                                 OutValid,
  input  logic                                 OutReady,
  output logic [DATA_W-1:0]                    OutData,
  output logic [$clog2(2*NUM_STAGES+1)-1:0]    Occupancy
);

  localparam int unsigned OCC_W   = pipe_occ_w(NUM_STAGES);
  localparam int unsigned OCC_MAX = SKID_EN ? 2 * NUM_STAGES : NUM_STAGES;

  logic [NUM_STAGES:0] vld;
  logic [NUM_STAGES:0] rdy;
  logic [DATA_W-1:0]   dat   [NUM_STAGES+1];
  logic [1:0]          cnt_d [NUM_STAGES];
  logic [OCC_W-1:0]    occupancy_q, occupancy_d;

  assign vld[0]          = InValid;
  assign dat[0]          = InData;
  assign rdy[NUM_STAGES] = OutReady;
  // A flushed input is dropped, so upstream must not see a stall for it.
  assign InReady         = rdy[0] || FlushQ;
  assign OutValid        = vld[NUM_STAGES];
  assign OutData         = dat[NUM_STAGES];
  assign Occupancy       = occupancy_q;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
    big_core_pipe_slot #(
      .DATA_W  (DATA_W),
      .SKID_EN (SKID_EN)
    ) u_slot (
      .clk         (Clock),
      .rst_n       (Rst),
      .flush       (FlushQ),
      .in_valid    (vld[g]),
      .in_ready    (rdy[g]),
      .in_data     (dat[g]),
      .out_valid   (vld[g+1]),
      .out_ready   (rdy[g+1]),
      .out_data    (dat[g+1]),
      .valid_cnt_d (cnt_d[g])
    );
  end

  // Count the valid bits every slot will hold after this edge.
  always_comb begin
    occupancy_d = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      occupancy_d = occupancy_d + OCC_W'(cnt_d[i]);
    end
  end

  // Occupancy register with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) occupancy_q <= '0;
    else      occupancy_q <= occupancy_d;
  end

  a_out_stable: assert property (@(posedge Clock) disable iff (!Rst)
    (OutValid && !OutReady && !FlushQ) |=> (OutValid && $stable(OutData)));

  a_occ_max: assert property (@(posedge Clock) disable iff (!Rst)
    Occupancy <= OCC_W'(OCC_MAX));

endmodule
